// File: rtl/pong_pkg.sv
// pong_pkg: shared channel indices, default debounce length and v_sync delay reset value
package pong_pkg;
  localparam int CH_UP_P0 = 0;
  localparam int CH_DOWN_P0 = 1;
  localparam int CH_UP_P1 = 2;
  localparam int CH_DOWN_P1 = 3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam logic V_SYNC_D_RST = 1'b1;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one-bit synchroniser + counter debouncer; clk/rst, i_raw async in, o_level debounced level, o_press 0->1 strobe
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_stable;
  logic r_press;
  logic w_sync;
  logic w_diff;
  logic w_fire;
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_diff = w_sync ^ r_stable;
  assign w_fire = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_stable <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_cnt <= (w_diff && !w_fire) ? r_cnt + CW'(1) : '0;
      r_stable <= w_fire ? w_sync : r_stable;
      r_press <= w_fire & w_sync;
    end
  end
  assign o_level = r_stable;
  assign o_press = r_press;
endmodule

// File: rtl/paddle_input_debounce.sv
// paddle_input_debounce: debounces raw_btn[3:0], resolves up/down conflicts and latches move_* on v_sync rising edge; outputs level_out, press_pulse, move_up/down_p0/p1
module paddle_input_debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raw_btn,
  input  logic       v_sync,
  output logic [3:0] level_out,
  output logic [3:0] press_pulse,
  output logic       move_up_p0,
  output logic       move_down_p0,
  output logic       move_up_p1,
  output logic       move_down_p1
);
  logic [3:0] w_partner;
  logic [3:0] w_req;
  logic [3:0] r_move;
  logic r_v_sync_d;
  logic w_frame;
  for (genvar i = 0; i < 4; i++) begin : gen_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .i_raw(raw_btn[i]),
      .o_level(level_out[i]),
      .o_press(press_pulse[i])
    );
  end
  // each channel's opposite direction on the same paddle; pressing both cancels
  assign w_partner = {level_out[CH_UP_P1], level_out[CH_DOWN_P1], level_out[CH_UP_P0], level_out[CH_DOWN_P0]};
  assign w_req = level_out & ~w_partner;
  assign w_frame = v_sync & ~r_v_sync_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_sync_d <= V_SYNC_D_RST;
      r_move <= '0;
    end else begin
      r_v_sync_d <= v_sync;
      r_move <= w_frame ? w_req : r_move;
    end
  end
  assign move_up_p0 = r_move[CH_UP_P0];
  assign move_down_p0 = r_move[CH_DOWN_P0];
  assign move_up_p1 = r_move[CH_UP_P1];
  assign move_down_p1 = r_move[CH_DOWN_P1];
endmodule
